// File: rtl/soml_pkg.sv
// Constants and types shared by the SOML frame loader and the decoder top.
package soml_pkg;

   localparam logic [7:0] FRAME_SOF = 8'hAA;
   localparam logic [7:0] TYPE_H    = 8'h48;
   localparam logic [7:0] TYPE_Y    = 8'h59;

   localparam int unsigned SOML_H_SAMPLES = 4;
   localparam int unsigned SOML_Y_SAMPLES = 2;

   typedef enum logic [2:0] {
      StIdle,
      StType,
      StPayload,
      StCheck,
      StEmit,
      StStart
   } state_e;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/byte_word_assembler.sv
// Collects BYTES bytes MSB first; done_o marks the byte that completes a word,
// with the full word presented on word_o in that same cycle.
module byte_word_assembler #(
   parameter int unsigned BYTES = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 clr_i,
   input  logic                 valid_i,
   input  logic [7:0]           byte_i,
   output logic [8*BYTES-1:0]   word_o,
   output logic                 done_o
);

   localparam int unsigned CNTW = (BYTES > 1) ? $clog2(BYTES) : 1;

   logic [8*BYTES-9:0] shift_q;
   logic [CNTW-1:0]    cnt_q;
   logic               last_byte;

   assign last_byte = (cnt_q == CNTW'(BYTES - 1));
   assign word_o    = {shift_q, byte_i};
   assign done_o    = valid_i && last_byte;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         shift_q <= '0;
         cnt_q   <= '0;
      end else if (clr_i) begin
         shift_q <= '0;
         cnt_q   <= '0;
      end else if (valid_i) begin
         shift_q <= word_o[8*BYTES-9:0];
         cnt_q   <= last_byte ? '0 : cnt_q + CNTW'(1);
      end
   end

endmodule

// File: rtl/soml_frame_loader.sv
// Hunts for 0xAA-framed H/Y packets, buffers a whole frame until its XOR checksum
// passes, then replays it to the decoder as single-cycle sample strobes.
module soml_frame_loader
   import soml_pkg::*;
#(
   parameter int unsigned N           = 32,
   parameter int unsigned H_SAMPLES   = SOML_H_SAMPLES,
   parameter int unsigned Y_SAMPLES   = SOML_Y_SAMPLES,
   parameter int unsigned TIMEOUT_CYC = 5_000_000
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [7:0]   rx_data,
   input  logic         rx_valid,
   output logic [N-1:0] H_in_r,
   output logic [N-1:0] H_in_i,
   output logic         H_in_valid,
   output logic [N-1:0] Y_in_r,
   output logic [N-1:0] Y_in_i,
   output logic         Y_in_valid,
   output logic         start,
   output logic         frame_ok,
   output logic         frame_err
);

   localparam int unsigned BPW   = N / 8;
   localparam int unsigned BSH   = $clog2(BPW);
   localparam int unsigned MAX_S = max_u(H_SAMPLES, Y_SAMPLES);
   localparam int unsigned SW    = (MAX_S > 1) ? $clog2(MAX_S) : 1;
   localparam int unsigned CW    = $clog2(2 * BPW * MAX_S + 1);
   localparam int unsigned TW    = $clog2(TIMEOUT_CYC + 1);

   state_e          state_q;
   logic            is_y_q;
   logic [7:0]      xor_q;
   logic [CW-1:0]   byte_cnt_q;
   logic [TW-1:0]   to_cnt_q;
   logic [SW-1:0]   emit_idx_q;
   logic [N-1:0]    h_r_q, h_i_q, y_r_q, y_i_q;
   logic            h_valid_q, y_valid_q, start_q, frame_ok_q, frame_err_q;
   logic [N-1:0]    buf_re_q [MAX_S];
   logic [N-1:0]    buf_im_q [MAX_S];

   logic            asm_valid, asm_clr, word_done;
   logic [N-1:0]    word;
   logic [CW-1:0]   pay_last;
   logic [SW-1:0]   emit_last;
   logic [SW-1:0]   slot_idx;
   logic            word_is_im;
   logic            in_frame;
   logic            to_hit;

   assign asm_valid  = rx_valid && (state_q == StPayload);
   assign asm_clr    = rx_valid && (state_q == StType);
   assign pay_last   = is_y_q ? CW'(2 * BPW * Y_SAMPLES - 1) : CW'(2 * BPW * H_SAMPLES - 1);
   assign emit_last  = is_y_q ? SW'(Y_SAMPLES - 1) : SW'(H_SAMPLES - 1);
   assign slot_idx   = SW'(byte_cnt_q >> (BSH + 1));
   assign word_is_im = byte_cnt_q[BSH];
   assign in_frame   = (state_q == StType) || (state_q == StPayload) || (state_q == StCheck);
   // Counter is reloaded with 1 on each byte so the error lands exactly TIMEOUT_CYC later.
   assign to_hit     = (to_cnt_q == TW'(TIMEOUT_CYC - 1));

   byte_word_assembler #(
      .BYTES (BPW)
   ) u_asm (
      .clk_i   (clk),
      .rst_i   (rst),
      .clr_i   (asm_clr),
      .valid_i (asm_valid),
      .byte_i  (rx_data),
      .word_o  (word),
      .done_o  (word_done)
   );

   always_ff @(posedge clk) begin
      if (word_done) begin
         if (word_is_im) buf_im_q[slot_idx] <= word;
         else            buf_re_q[slot_idx] <= word;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         is_y_q      <= 1'b0;
         xor_q       <= '0;
         byte_cnt_q  <= '0;
         to_cnt_q    <= '0;
         emit_idx_q  <= '0;
         h_r_q       <= '0;
         h_i_q       <= '0;
         y_r_q       <= '0;
         y_i_q       <= '0;
         h_valid_q   <= 1'b0;
         y_valid_q   <= 1'b0;
         start_q     <= 1'b0;
         frame_ok_q  <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         h_valid_q   <= 1'b0;
         y_valid_q   <= 1'b0;
         start_q     <= 1'b0;
         frame_ok_q  <= 1'b0;
         frame_err_q <= 1'b0;

         if (in_frame && !rx_valid) begin
            if (to_hit) begin
               frame_err_q <= 1'b1;
               state_q     <= StIdle;
            end else begin
               to_cnt_q <= to_cnt_q + TW'(1);
            end
         end

         case (state_q)
            StIdle: begin
               if (rx_valid && (rx_data == FRAME_SOF)) begin
                  to_cnt_q <= TW'(1);
                  state_q  <= StType;
               end
            end
            StType: begin
               if (rx_valid) begin
                  to_cnt_q <= TW'(1);
                  if ((rx_data == TYPE_H) || (rx_data == TYPE_Y)) begin
                     is_y_q     <= (rx_data == TYPE_Y);
                     xor_q      <= rx_data;
                     byte_cnt_q <= '0;
                     state_q    <= StPayload;
                  end else begin
                     frame_err_q <= 1'b1;
                     state_q     <= StIdle;
                  end
               end
            end
            StPayload: begin
               if (rx_valid) begin
                  to_cnt_q   <= TW'(1);
                  xor_q      <= xor_q ^ rx_data;
                  byte_cnt_q <= byte_cnt_q + CW'(1);
                  if (byte_cnt_q == pay_last) state_q <= StCheck;
               end
            end
            StCheck: begin
               if (rx_valid) begin
                  emit_idx_q <= '0;
                  if (rx_data == xor_q) begin
                     frame_ok_q <= 1'b1;
                     state_q    <= StEmit;
                  end else begin
                     frame_err_q <= 1'b1;
                     state_q     <= StIdle;
                  end
               end
            end
            StEmit: begin
               // A byte arriving while replaying is dropped but flagged.
               frame_err_q <= rx_valid;
               if (is_y_q) begin
                  y_r_q     <= buf_re_q[emit_idx_q];
                  y_i_q     <= buf_im_q[emit_idx_q];
                  y_valid_q <= 1'b1;
               end else begin
                  h_r_q     <= buf_re_q[emit_idx_q];
                  h_i_q     <= buf_im_q[emit_idx_q];
                  h_valid_q <= 1'b1;
               end
               emit_idx_q <= emit_idx_q + SW'(1);
               if (emit_idx_q == emit_last) state_q <= is_y_q ? StStart : StIdle;
            end
            StStart: begin
               frame_err_q <= rx_valid;
               start_q     <= 1'b1;
               state_q     <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign H_in_r     = h_r_q;
   assign H_in_i     = h_i_q;
   assign H_in_valid = h_valid_q;
   assign Y_in_r     = y_r_q;
   assign Y_in_i     = y_i_q;
   assign Y_in_valid = y_valid_q;
   assign start      = start_q;
   assign frame_ok   = frame_ok_q;
   assign frame_err  = frame_err_q;

endmodule

// File: doc/soml_frame_loader.md
# soml_frame_loader

Byte-stream frame parser between the UART receiver and `soml_decoder_top`. It hunts for framed H/Y packets in the received byte stream, assembles big-endian Q22 32-bit complex samples, and buffers a whole frame until its checksum passes. It then replays the frame to the decoder as single-cycle `H_in_valid` / `Y_in_valid` strobes, and issues `start` after a valid Y frame. Corrupt, truncated or stalled frames are discarded and never reach the decoder.

## Interface
Parameters:
- `N`, 32: sample word width (re and im each).
- `H_SAMPLES`, 4: complex samples per H frame (2x2 channel, row-major).
- `Y_SAMPLES`, 2: complex samples per Y frame.
- `TIMEOUT_CYC`, 5_000_000: idle cycles inside a frame before abort (100 ms @ 50 MHz).

Ports:
- `clk` in 1: system clock, 50 MHz.
- `rst` in 1: asynchronous, active-high reset.
- `rx_data` in 8: received byte.
- `rx_valid` in 1: one-cycle strobe, `rx_data` valid.
- `H_in_r`, `H_in_i` out N: H sample real/imag.
- `H_in_valid` out 1: one-cycle H sample strobe.
- `Y_in_r`, `Y_in_i` out N: Y sample real/imag.
- `Y_in_valid` out 1: one-cycle Y sample strobe.
- `start` out 1: one-cycle decoder start pulse.
- `frame_ok` out 1: one-cycle pulse, frame accepted.
- `frame_err` out 1: one-cycle pulse, frame rejected (checksum, bad type, timeout, overrun).

## Operation
- Frame: `0xAA`, type (`0x48` = H, `0x59` = Y), payload, checksum.
- Payload: per sample, re then im, each 4 bytes MSB first.
- Payload length is 8 × `H_SAMPLES` or 8 × `Y_SAMPLES` bytes.
- Checksum byte equals the XOR of the type byte and all payload bytes.
- FSM states: `IDLE`, `TYPE`, `PAYLOAD`, `CHECK`, `EMIT`, `START`.
  - `IDLE`: on `rx_valid` with `0xAA` -> `TYPE`. Any other byte is ignored silently.
  - `TYPE`: `0x48`/`0x59` latches the kind, clears XOR accumulator and byte counter -> `PAYLOAD`. Any other byte -> `frame_err` pulse, then `IDLE`. A repeated `0xAA` is also an error.
  - `PAYLOAD`: shift each byte into a 32-bit assembler. Every 4th byte writes re or im into buffer slot `byte_cnt>>3`. After the last payload byte -> `CHECK`.
  - `CHECK`: byte equal to accumulated XOR -> `frame_ok` pulse, then `EMIT`. Otherwise -> `frame_err` pulse, buffer discarded, then `IDLE`.
  - `EMIT`: replay slots 0..count-1, one per cycle, on the H or Y output set. After the last slot -> `START` if Y, else `IDLE`.
  - `START`: single-cycle `start` pulse -> `IDLE`.
- Timeout: cycle counter clears on every accepted byte and runs in `TYPE`/`PAYLOAD`/`CHECK`. Reaching `TIMEOUT_CYC` -> `frame_err` pulse, then `IDLE`.
- `rx_valid` during `EMIT`/`START`: byte dropped, `frame_err` pulsed, FSM continues emitting. At 50 MHz and standard UART rates this is unreachable.
- H frame alone never raises `start`. Y frame always raises `start`, with no interlock against a previously missing H; host sequencing owns that.
- Buffer: `max(H_SAMPLES, Y_SAMPLES)` × 2N bits, registers, overwritten by each new frame.
- Reset mid-frame: FSM to `IDLE`, counters cleared, buffer contents don't-care.

## Timing
- All outputs registered. On reset, every data output is 0 and every strobe/pulse is 0.
- Data outputs hold the last emitted value between strobes.
- Checksum byte accepted in cycle T:
  - `frame_ok` high in T+1.
  - First `*_in_valid` in T+2; samples on consecutive cycles.
  - Last sample in T+1+count.
  - `start` (Y only) in T+2+count.
- `H_in_valid` and `Y_in_valid` are never high together.
- `start` is never coincident with a data strobe.
- `frame_ok` and `frame_err` are never high in the same cycle.
- Timeout fires exactly `TIMEOUT_CYC` cycles after the last accepted in-frame byte.

## Structure
- Shared package `soml_pkg`: `FRAME_SOF = 8'hAA`, `TYPE_H = 8'h48`, `TYPE_Y = 8'h59`, the state enum, and the H/Y sample counts shared with `soml_decoder_top`.
- One sub-module, `byte_word_assembler`: 4-byte MSB-first shift register with a word-complete strobe. FSM, XOR, timeout and buffer stay in the top.

## Test plan
- Valid H frame, samples re=`0x00400000`·k, im=−k: four `H_in_valid` strobes on consecutive cycles, exact values. No `start`. `frame_ok` once.
- Valid Y frame, 2 samples: two `Y_in_valid` strobes, then `start` exactly one cycle after the last. Latency checked against T+2 / T+2+count.
- H frame with checksum byte XOR `0x01`: `frame_err` once. No data strobes. The next valid frame is accepted normally.
- Garbage `0x00 0x55 0xAA 0x13`: bytes before `0xAA` ignored. Type `0x13` -> `frame_err`, return to `IDLE`.
- Y frame stalled after 5 payload bytes with `TIMEOUT_CYC`=100: `frame_err` at cycle 100. Subsequent valid frame decoded correctly.
- Assert `rst` during `PAYLOAD`, then send a valid H frame: all outputs 0 during reset, and the frame is replayed with correct data.
